// File: rtl/jtframe_z80_dma_pkg.sv
// Shared types for the Z80 bus-master block copier.
package jtframe_z80_dma_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {IDLE, REQ, RD, DATA, REL} state_t;
endpackage

// File: rtl/jtframe_z80_dma.sv
// Borrows the Z80 bus via BUSRQ_n/BUSAK_n and streams a block of shared RAM
// bytes into an external sink with ready/valid handshaking.
module jtframe_z80_dma
  import jtframe_z80_dma_pkg::*;
#(
  parameter int AW = 12,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_din,
  output logic [7:0]    sink_data,
  output logic          sink_we,
  input  logic          sink_ready
);
  state_t        state, nxt;
  logic [AW-1:0] addr, addr_q;
  logic [LW-1:0] cnt;
  logic [7:0]    data_q;
  logic          fresh, done_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start && len != '0) nxt = REQ;
      REQ:  if (!busak_n) nxt = RD;
      RD:   nxt = busak_n ? REQ : DATA;
      DATA: begin
        if (busak_n)         nxt = REQ;
        else if (sink_ready) nxt = (cnt == LW'(1)) ? REL : RD;
      end
      REL:  if (busak_n) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // RAM data arrives in the first DATA cycle; it is passed straight through
  // then, and held from data_q while the sink stalls.
  assign busrq_n   = !(state == REQ || state == RD || state == DATA);
  assign busy      = state != IDLE;
  assign done      = done_q;
  assign ram_rd    = state == RD && !busak_n;
  assign sink_we   = state == DATA && !busak_n;
  assign ram_addr  = (state == RD) ? addr : addr_q;
  assign sink_data = fresh ? ram_din : data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      addr_q <= '0;
      cnt    <= '0;
      data_q <= '0;
      fresh  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= 1'b0;
      fresh  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (len != '0) begin
            addr <= src_addr;
            cnt  <= len;
          end else begin
            done_q <= 1'b1;
          end
        end
        RD: begin
          addr_q <= addr;
          fresh  <= !busak_n;
        end
        DATA: begin
          if (fresh) data_q <= ram_din;
          // a lost bus masks sink_we, so a dropped byte never advances
          if (sink_we && sink_ready) begin
            addr <= addr + AW'(1);
            cnt  <= cnt - LW'(1);
          end
        end
        REL: if (busak_n) done_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
